press_counter: RTL and testbench
================================

# press_counter

Counts debounced button presses and drives a two-digit seven-segment display. Sits directly downstream of the button debouncer and consumes its clean level output. Each released-to-pressed transition adds one to a two-digit BCD count that wraps at 99. Holding the button continuously for `Hold_Time` cycles clears the count to 00.

## Interface
Parameters:
- `Hold_Time`, default 25000000 — press duration in cycles that triggers a clear (1 s at 25 MHz). Legal range ≥ 2.

Ports:
- `CLK`  in  1 — single system clock; all state on its rising edge.
- `i_Reset`  in  1 — asynchronous, active-high reset.
- `i_Button_State`  in  1 — debounced button level from the debouncer, 1 = pressed; synchronous to `CLK`.
- `o_Ones`  out  4 — BCD ones digit, 0–9.
- `o_Tens`  out  4 — BCD tens digit, 0–9.
- `o_Segment_Ones`  out  7 — active-low segments for the ones digit; bit0 = a … bit6 = g.
- `o_Segment_Tens`  out  7 — same encoding, tens digit.
- `o_Press_Pulse`  out  1 — one-cycle pulse per counted press.
- `o_Cleared`  out  1 — one-cycle pulse when a long hold clears the count.

## Operation
- Edge detect: a registered copy `Button_Prev` of `i_Button_State`. A press is `i_Button_State`=1 with `Button_Prev`=0. The reset value of `Button_Prev` is 1, so a button held through reset is not counted until it is released and pressed again.
- FSM states:
  - **IDLE** (button released).
  - **PRESSED** (held, hold timer running).
  - **HELD** (clear done, waiting for release).
- FSM transitions:
  - IDLE → PRESSED on a press: count increments, `o_Press_Pulse`=1, timer←0.
  - PRESSED, input 1, timer ≠ Hold_Time−1: timer++.
  - PRESSED, input 1, timer = Hold_Time−1: count←00, `o_Cleared`=1, → HELD.
  - PRESSED, input 0: → IDLE with no clear. This applies even in the cycle where the timer would have expired; release wins.
  - HELD, input 0: → IDLE. HELD, input 1: stay, no further action.
- Count arithmetic: BCD. Ones 9→0 carries into tens. 99→00 on a press; the wrap raises `o_Press_Pulse` only, never `o_Cleared`. No carry-out port.
- Hold timer: unsigned, width $clog2(Hold_Time); never exceeds Hold_Time−1.
- Segment decode: combinational from the registered BCD digits. Values, active-low, written as bit6..bit0 in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Out-of-range digits decode to 7F (blank); these are unreachable.
- Reset (asynchronous, any time including mid-hold):
  - count=00, so `o_Ones`=`o_Tens`=0 and both segment outputs=40.
  - `o_Press_Pulse`=`o_Cleared`=0.
  - State=IDLE, timer=0, `Button_Prev`=1.

## Timing
- Press latency: if `i_Button_State` rises and is sampled at edge N, then the count, digits, segments and `o_Press_Pulse` are all valid after edge N. The pulse is high for exactly cycle N→N+1.
- Clear latency: with the press sampled at edge N and the input held high through edge N+Hold_Time, the count becomes 00 and `o_Cleared` is high after edge N+Hold_Time.
  - If the input is 0 at that edge, no clear occurs.
  - The count goes +1 then 00, so the clearing press is discarded.
- `o_Press_Pulse` and `o_Cleared` are never high in the same cycle (Hold_Time ≥ 2).
- Minimum press spacing: one low sample between presses. High-low-high on consecutive edges counts twice.
- All outputs are registered except the segment decode, which is a pure function of the registered digits (no added latency).

## Test plan
- **Reset:** assert `i_Reset` with no clock running.
  - Outputs immediately: digits 0/0, segments 40/40, pulses 0.
  - Hold the button high through release of reset → count stays 00.
  - Release the button, then press → 01.
- **Basic count:** `Hold_Time`=16; three presses, each 5 cycles high and 5 low.
  - Count reaches 03, `o_Segment_Ones`=30, `o_Segment_Tens`=40.
  - Exactly three single-cycle `o_Press_Pulse`, each in the cycle after the first high sample.
- **Wrap:** 100 short presses.
  - After the 99th: `o_Tens`=9, `o_Ones`=9, both segments=10.
  - The 100th gives 00 with `o_Press_Pulse`=1 and `o_Cleared`=0.
- **Long hold:** from count 05, hold high for 80 cycles with `Hold_Time`=16.
  - 06 after the press edge.
  - 00 and a single `o_Cleared` pulse 16 edges later; no further change while held.
  - Release, then press → 01.
- **Release at expiry:** from count 05, press with the input low at edge N+16 (high samples N..N+15).
  - Count 06, `o_Cleared` never asserts.
  - Next press → 07.
- **Reset mid-hold:** count 42, button held, timer mid-count; assert `i_Reset` asynchronously.
  - Outputs read 00 before the next clock edge.
  - After release with the button still held: no count until a release–press sequence occurs.

Source files
------------

// File: rtl/press_counter.sv
// press_counter: counts debounced button presses as a two-digit BCD value
// (wrapping at 99) and drives two active-low seven-segment digits. A press
// held for Hold_Time cycles clears the count to 00.
module press_counter #(
    parameter int Hold_Time = 25000000
) (
    input  logic       CLK,
    input  logic       i_Reset,
    input  logic       i_Button_State,
    output logic [3:0] o_Ones,
    output logic [3:0] o_Tens,
    output logic [6:0] o_Segment_Ones,
    output logic [6:0] o_Segment_Tens,
    output logic       o_Press_Pulse,
    output logic       o_Cleared
);

    // state     | meaning
    // ST_IDLE   | button released, waiting for a press
    // ST_PRESSED| button held, hold timer running
    // ST_HELD   | long-hold clear done, waiting for release
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int TW = (Hold_Time > 2) ? $clog2(Hold_Time) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(Hold_Time - 1);

    state_t          r_State;
    state_t          w_Next_State;
    logic            r_Button_Prev;
    logic [TW-1:0]   r_Timer;
    logic [3:0]      r_Ones;
    logic [3:0]      r_Tens;
    logic            r_Press_Pulse;
    logic            r_Cleared;

    logic            w_Press;
    logic            w_Timer_Done;
    logic            w_Count_Inc;
    logic            w_Count_Clr;
    logic            w_Timer_Inc;

    // Button_Prev resets to 1 so a button held through reset is not a press.
    assign w_Press      = i_Button_State & ~r_Button_Prev;
    assign w_Timer_Done = (r_Timer == TIMER_MAX);

    // State register.
    always_ff @(posedge CLK or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= ST_IDLE;
        end else begin
            r_State <= w_Next_State;
        end
    end

    // Next-state logic; a release always wins over timer expiry.
    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            ST_IDLE: begin
                if (w_Press) w_Next_State = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!i_Button_State)   w_Next_State = ST_IDLE;
                else if (w_Timer_Done) w_Next_State = ST_HELD;
            end
            ST_HELD: begin
                if (!i_Button_State) w_Next_State = ST_IDLE;
            end
            default: w_Next_State = ST_IDLE;
        endcase
    end

    // Output decode: datapath actions for the current state and input.
    always_comb begin
        w_Count_Inc = 1'b0;
        w_Count_Clr = 1'b0;
        w_Timer_Inc = 1'b0;
        case (r_State)
            ST_IDLE: begin
                w_Count_Inc = w_Press;
            end
            ST_PRESSED: begin
                w_Count_Clr = i_Button_State & w_Timer_Done;
                w_Timer_Inc = i_Button_State & ~w_Timer_Done;
            end
            default: ;
        endcase
    end

    // Datapath: edge history, hold timer, BCD count and event pulses.
    always_ff @(posedge CLK or posedge i_Reset) begin
        if (i_Reset) begin
            r_Button_Prev <= 1'b1;
            r_Timer       <= '0;
            r_Ones        <= 4'd0;
            r_Tens        <= 4'd0;
            r_Press_Pulse <= 1'b0;
            r_Cleared     <= 1'b0;
        end else begin
            r_Button_Prev <= i_Button_State;
            r_Press_Pulse <= w_Count_Inc;
            r_Cleared     <= w_Count_Clr;
            if (w_Count_Inc) begin
                r_Timer <= '0;
            end else if (w_Timer_Inc) begin
                r_Timer <= r_Timer + 1'b1;
            end
            if (w_Count_Clr) begin
                r_Ones <= 4'd0;
                r_Tens <= 4'd0;
            end else if (w_Count_Inc) begin
                if (r_Ones == 4'd9) begin
                    r_Ones <= 4'd0;
                    r_Tens <= (r_Tens == 4'd9) ? 4'd0 : r_Tens + 4'd1;
                end else begin
                    r_Ones <= r_Ones + 4'd1;
                end
            end
        end
    end

    // Active-low segment decode, bit6..bit0 = g..a; out-of-range is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] i_Digit);
        case (i_Digit)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // Segment outputs follow the registered digits with no added latency.
    always_comb begin
        o_Segment_Ones = seg_decode(r_Ones);
        o_Segment_Tens = seg_decode(r_Tens);
    end

    assign o_Ones        = r_Ones;
    assign o_Tens        = r_Tens;
    assign o_Press_Pulse = r_Press_Pulse;
    assign o_Cleared     = r_Cleared;

endmodule

// File: tb/tb_press_counter.sv
// Directed testbench for press_counter with Hold_Time = 16.
module tb_press_counter;

    logic       CLK;
    logic       clk_en;
    logic       i_Reset;
    logic       i_Button_State;
    logic [3:0] o_Ones;
    logic [3:0] o_Tens;
    logic [6:0] o_Segment_Ones;
    logic [6:0] o_Segment_Tens;
    logic       o_Press_Pulse;
    logic       o_Cleared;

    int errors = 0;
    int checks = 0;
    int clr_seen = 0;
    int pulse_seen = 0;
    int base;

    press_counter #(.Hold_Time(16)) dut (
        .CLK            (CLK),
        .i_Reset        (i_Reset),
        .i_Button_State (i_Button_State),
        .o_Ones         (o_Ones),
        .o_Tens         (o_Tens),
        .o_Segment_Ones (o_Segment_Ones),
        .o_Segment_Tens (o_Segment_Tens),
        .o_Press_Pulse  (o_Press_Pulse),
        .o_Cleared      (o_Cleared)
    );

    initial CLK = 1'b0;
    always #5 if (clk_en) CLK = ~CLK;

    // One rising edge, then settle 1 time unit and tally event pulses.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (o_Cleared) clr_seen++;
        if (o_Press_Pulse) pulse_seen++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_count(input string tag, input int tens, input int ones);
        chk({tag, " tens"}, {28'd0, o_Tens}, tens[31:0]);
        chk({tag, " ones"}, {28'd0, o_Ones}, ones[31:0]);
    endtask

    task automatic short_press();
        i_Button_State = 1'b1;
        tick();
        i_Button_State = 1'b0;
        tick();
    endtask

    // Asynchronous reset pulse between edges, followed by one low sample.
    task automatic do_reset();
        i_Button_State = 1'b0;
        i_Reset = 1'b1;
        #2;
        i_Reset = 1'b0;
        tick();
    endtask

    initial begin
        clk_en = 1'b0;
        i_Reset = 1'b1;
        i_Button_State = 1'b1;
        #2;
        // Reset without a clock.
        chk_count("rst_noclk", 0, 0);
        chk("rst_seg_ones", {25'd0, o_Segment_Ones}, 32'h40);
        chk("rst_seg_tens", {25'd0, o_Segment_Tens}, 32'h40);
        chk("rst_pulse", {31'd0, o_Press_Pulse}, 32'd0);
        chk("rst_cleared", {31'd0, o_Cleared}, 32'd0);

        clk_en = 1'b1;
        tick();
        tick();
        i_Reset = 1'b0;
        repeat (4) tick();
        chk_count("held_thru_reset", 0, 0);
        chk("held_thru_reset_pulses", pulse_seen, 32'd0);
        i_Button_State = 1'b0;
        repeat (2) tick();
        i_Button_State = 1'b1;
        tick();
        chk_count("first_press", 0, 1);
        chk("first_press_pulse", {31'd0, o_Press_Pulse}, 32'd1);
        tick();
        chk("first_press_pulse_end", {31'd0, o_Press_Pulse}, 32'd0);

        // Basic count: three presses, 5 high / 5 low.
        do_reset();
        chk_count("basic_reset", 0, 0);
        base = pulse_seen;
        for (int p = 1; p <= 3; p++) begin
            i_Button_State = 1'b1;
            tick();
            chk("basic_pulse_hi", {31'd0, o_Press_Pulse}, 32'd1);
            chk_count("basic_step", 0, p);
            tick();
            chk("basic_pulse_lo", {31'd0, o_Press_Pulse}, 32'd0);
            repeat (3) tick();
            i_Button_State = 1'b0;
            repeat (5) tick();
        end
        chk_count("basic_final", 0, 3);
        chk("basic_seg_ones", {25'd0, o_Segment_Ones}, 32'h30);
        chk("basic_seg_tens", {25'd0, o_Segment_Tens}, 32'h40);
        chk("basic_pulse_count", pulse_seen - base, 32'd3);

        // Wrap at 99 using high-low-high spacing.
        do_reset();
        for (int p = 0; p < 99; p++) short_press();
        chk_count("wrap_99", 9, 9);
        chk("wrap_seg_ones", {25'd0, o_Segment_Ones}, 32'h10);
        chk("wrap_seg_tens", {25'd0, o_Segment_Tens}, 32'h10);
        base = clr_seen;
        i_Button_State = 1'b1;
        tick();
        chk_count("wrap_00", 0, 0);
        chk("wrap_pulse", {31'd0, o_Press_Pulse}, 32'd1);
        chk("wrap_cleared", {31'd0, o_Cleared}, 32'd0);
        i_Button_State = 1'b0;
        tick();
        chk("wrap_no_clear", clr_seen - base, 32'd0);

        // Long hold from 05.
        do_reset();
        for (int p = 0; p < 5; p++) short_press();
        base = clr_seen;
        i_Button_State = 1'b1;
        tick();
        chk_count("hold_press", 0, 6);
        repeat (15) tick();
        chk_count("hold_edge15", 0, 6);
        chk("hold_edge15_cleared", clr_seen - base, 32'd0);
        tick();
        chk_count("hold_clear", 0, 0);
        chk("hold_cleared", {31'd0, o_Cleared}, 32'd1);
        chk("hold_pulse", {31'd0, o_Press_Pulse}, 32'd0);
        repeat (64) tick();
        chk_count("hold_still", 0, 0);
        chk("hold_single_clear", clr_seen - base, 32'd1);
        i_Button_State = 1'b0;
        repeat (2) tick();
        i_Button_State = 1'b1;
        tick();
        chk_count("hold_repress", 0, 1);

        // Release exactly at expiry: no clear.
        do_reset();
        for (int p = 0; p < 5; p++) short_press();
        base = clr_seen;
        i_Button_State = 1'b1;
        tick();
        chk_count("expiry_press", 0, 6);
        repeat (15) tick();
        i_Button_State = 1'b0;
        repeat (3) tick();
        chk_count("expiry_release", 0, 6);
        chk("expiry_no_clear", clr_seen - base, 32'd0);
        i_Button_State = 1'b1;
        tick();
        chk_count("expiry_next", 0, 7);

        // Reset mid-hold at count 42.
        do_reset();
        for (int p = 0; p < 41; p++) short_press();
        i_Button_State = 1'b1;
        tick();
        chk_count("midhold_42", 4, 2);
        repeat (5) tick();
        #2;
        i_Reset = 1'b1;
        #1;
        chk_count("midhold_async", 0, 0);
        chk("midhold_seg_ones", {25'd0, o_Segment_Ones}, 32'h40);
        chk("midhold_seg_tens", {25'd0, o_Segment_Tens}, 32'h40);
        tick();
        i_Reset = 1'b0;
        base = pulse_seen + clr_seen;
        repeat (20) tick();
        chk_count("midhold_held", 0, 0);
        chk("midhold_no_events", pulse_seen + clr_seen - base, 32'd0);
        i_Button_State = 1'b0;
        tick();
        i_Button_State = 1'b1;
        tick();
        chk_count("midhold_repress", 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
